// File: rtl/compare_seq_ctrl_pkg.sv
// Shared definitions for the sequential branch-condition compare:
// condition codes and FSM state encoding.
package compare_seq_ctrl_pkg;

    localparam logic [2:0] CC_LT      = 3'b000;
    localparam logic [2:0] CC_GT      = 3'b001;
    localparam logic [2:0] CC_LE      = 3'b010;
    localparam logic [2:0] CC_GE      = 3'b011;
    localparam logic [2:0] CC_NE      = 3'b100;
    localparam logic [2:0] CC_EQ      = 3'b110;
    localparam logic [2:0] CC_INVALID = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/compare_seq_ctrl_if.sv
// Request/response bundle between branch decode and the sequential compare.
interface compare_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    // Both channels: a transfer happens on a rising clk edge where valid & ready
    // are high; the sender holds valid and payload stable until that edge.
    logic             req_valid_i;
    logic             req_ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [2:0]       comp_i;
    logic             signed_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             result_o;
    logic             less_o;
    logic             equal_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, src1_i, src2_i, comp_i, signed_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, result_o, less_o, equal_o, busy_o
    );

    modport master (
        output req_valid_i, src1_i, src2_i, comp_i, signed_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, result_o, less_o, equal_o, busy_o
    );
endinterface

// File: rtl/compare_seq_ctrl_cond_eval.sv
// Combinational condition evaluation from (less, equal, condition code).
module compare_seq_ctrl_cond_eval
    import compare_seq_ctrl_pkg::*;
(
    input  logic       less,
    input  logic       equal,
    input  logic [2:0] comp,
    output logic       result
);

    always_comb begin
        result = 1'b0;
        case (comp)
            CC_LT:   result = less & ~equal;
            CC_GT:   result = ~less & ~equal;
            CC_LE:   result = less | equal;
            CC_GE:   result = ~less | equal;
            CC_EQ:   result = equal & ~less;
            CC_NE:   result = ~equal;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/compare_seq_ctrl.sv
// Multi-cycle compare: scans operands MSB chunk first, CHUNK bits per clock.
// Define COMPARE_SEQ_EARLY_EXIT_EN to finish the scan at the first differing chunk.
module compare_seq_ctrl
    import compare_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    compare_seq_ctrl_if.slave   bus,
    output state_t              state_o
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t             state, state_n;
    logic [IW-1:0]      idx;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2:0]         comp_r;
    logic               signed_r;
    logic               lt_r, eq_r;
    logic               result_r, less_r, equal_r;

    logic [CHUNK-1:0]   chunk_a, chunk_b;
    logic               chunk_lt;
    logic               lt_n, eq_n;
    logic               scan_exit;
    logic               cond_out;
    logic               accept;

    assign accept          = bus.req_valid_i && (state == IDLE);
    assign bus.req_ready_o = (state == IDLE);
    assign bus.busy_o      = (state != IDLE);
    assign bus.rsp_valid_o = (state == DONE);
    assign bus.result_o    = result_r;
    assign bus.less_o      = less_r;
    assign bus.equal_o     = equal_r;
    assign state_o         = state;

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IW'(k)) begin
                chunk_a = a_r[k*CHUNK +: CHUNK];
                chunk_b = b_r[k*CHUNK +: CHUNK];
            end
        end
    end

    // Only the top chunk carries the sign; lower chunks are magnitude bits.
    always_comb begin
        if (signed_r && (idx == IW'(NCHUNK-1)))
            chunk_lt = ($signed(chunk_a) < $signed(chunk_b));
        else
            chunk_lt = (chunk_a < chunk_b);
    end

    assign eq_n = eq_r & (chunk_a == chunk_b);
    assign lt_n = (eq_r && (chunk_a != chunk_b)) ? chunk_lt : lt_r;

`ifdef COMPARE_SEQ_EARLY_EXIT_EN
    assign scan_exit = (idx == '0) || (eq_r && !eq_n);
`else
    assign scan_exit = (idx == '0);
`endif

    // Evaluated on the post-update flags so the DONE-entry register sees the final chunk.
    compare_seq_ctrl_cond_eval u_cond_eval (
        .less   (lt_n),
        .equal  (eq_n),
        .comp   (comp_r),
        .result (cond_out)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SCAN;
            SCAN:    if (scan_exit) state_n = DONE;
            DONE:    if (bus.rsp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            comp_r   <= '0;
            signed_r <= 1'b0;
            lt_r     <= 1'b0;
            eq_r     <= 1'b0;
            result_r <= 1'b0;
            less_r   <= 1'b0;
            equal_r  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r      <= bus.src1_i;
                        b_r      <= bus.src2_i;
                        comp_r   <= bus.comp_i;
                        signed_r <= bus.signed_i;
                        idx      <= IW'(NCHUNK-1);
                        eq_r     <= 1'b1;
                        lt_r     <= 1'b0;
                    end
                end
                SCAN: begin
                    lt_r <= lt_n;
                    eq_r <= eq_n;
                    idx  <= idx - 1'b1;
                    if (scan_exit) begin
                        result_r <= cond_out;
                        less_r   <= lt_n;
                        equal_r  <= eq_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Directed-vector bench for compare_seq_ctrl (WIDTH=32, CHUNK=8).
module tb_compare_seq_ctrl;
    import compare_seq_ctrl_pkg::*;

    logic   clk_i;
    logic   rst_i;
    state_t state_o;
    int     n_cmp;
    int     n_err;

    compare_seq_ctrl_if #(.WIDTH(32)) bus ();

    compare_seq_ctrl #(.WIDTH(32), .CHUNK(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for the response and check it; optionally complete the handshake.
    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] c, input logic s, input logic exp_res,
                          input logic exp_less, input logic exp_eq,
                          input int lat_off, input int lat_on, input bit hs);
        int lat;
        @(negedge clk_i);
        bus.src1_i      = a;
        bus.src2_i      = b;
        bus.comp_i      = c;
        bus.signed_i    = s;
        bus.req_valid_i = 1'b1;
        check({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        lat = 0;
        while (!bus.rsp_valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
`ifdef COMPARE_SEQ_EARLY_EXIT_EN
        check({tag, "_latency"}, 32'(lat), 32'(lat_on));
`else
        check({tag, "_latency"}, 32'(lat), 32'(lat_off));
`endif
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        check({tag, "_result"}, 32'(bus.result_o), 32'(exp_res));
        check({tag, "_less"}, 32'(bus.less_o), 32'(exp_less));
        check({tag, "_equal"}, 32'(bus.equal_o), 32'(exp_eq));
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        if (hs) begin
            @(negedge clk_i);
            bus.rsp_ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            bus.rsp_ready_i = 1'b0;
            check({tag, "_rsp_drop"}, 32'(bus.rsp_valid_o), 32'd0);
            check({tag, "_idle"}, 32'(state_o), 32'(IDLE));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.src1_i      = '0;
        bus.src2_i      = '0;
        bus.comp_i      = '0;
        bus.signed_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_result", 32'(bus.result_o), 32'd0);
        check("rst_less", 32'(bus.less_o), 32'd0);
        check("rst_equal", 32'(bus.equal_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Basic ordering, sign handling and the condition table.
        do_req("t1_lt",    32'd5,        32'd7,        CC_LT, 1'b1, 1, 1, 0, 4, 4, 1);
        do_req("t2_gt_s",  32'hFFFFFFFF, 32'd1,        CC_GT, 1'b1, 0, 1, 0, 4, 1, 1);
        do_req("t2_gt_u",  32'hFFFFFFFF, 32'd1,        CC_GT, 1'b0, 1, 0, 0, 4, 1, 1);
        do_req("t3_eq",    32'h12345678, 32'h12345678, CC_EQ, 1'b0, 1, 0, 1, 4, 4, 1);
        do_req("t3_ne",    32'h12345678, 32'h12345678, CC_NE, 1'b0, 0, 0, 1, 4, 4, 1);
        do_req("t3_le",    32'h12345678, 32'h12345678, CC_LE, 1'b1, 1, 0, 1, 4, 4, 1);
        do_req("t3_inv",   32'h12345678, 32'h12345678, CC_INVALID, 1'b0, 0, 0, 1, 4, 4, 1);
        do_req("t3_c101",  32'h12345678, 32'h12345678, 3'b101, 1'b0, 0, 0, 1, 4, 4, 1);
        do_req("ge_false", 32'd5,        32'd7,        CC_GE, 1'b0, 0, 1, 0, 4, 4, 1);
        do_req("gt_mid",   32'h00120000, 32'h00110000, CC_GT, 1'b0, 1, 0, 0, 4, 2, 1);

        // Backpressure: response held while a new request is offered.
        do_req("t4_hold",  32'd1,        32'd2,        CC_LT, 1'b0, 1, 1, 0, 4, 4, 0);
        @(negedge clk_i);
        bus.src1_i      = 32'd9;
        bus.src2_i      = 32'd4;
        bus.comp_i      = CC_EQ;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("t4_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("t4_hold_result", 32'(bus.result_o), 32'd1);
            check("t4_hold_req_ready", 32'(bus.req_ready_o), 32'd0);
            check("t4_hold_state", 32'(state_o), 32'(DONE));
        end
        @(negedge clk_i);
        bus.rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b0;
        check("t4_after_hs_state", 32'(state_o), 32'(IDLE));
        check("t4_after_hs_ready", 32'(bus.req_ready_o), 32'd1);
        do_req("t4_next", 32'd9, 32'd4, CC_GT, 1'b0, 1, 0, 0, 4, 4, 1);

        // Asynchronous reset during the second scan cycle drops the request.
        @(negedge clk_i);
        bus.src1_i      = 32'd100;
        bus.src2_i      = 32'd200;
        bus.comp_i      = CC_LT;
        bus.signed_i    = 1'b0;
        bus.req_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk_i);
        #2;
        check("t5_pre_state", 32'(state_o), 32'(SCAN));
        rst_i = 1'b0;
        #1;
        check("t5_state", 32'(state_o), 32'(IDLE));
        check("t5_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("t5_result", 32'(bus.result_o), 32'd0);
        check("t5_less", 32'(bus.less_o), 32'd0);
        check("t5_equal", 32'(bus.equal_o), 32'd0);
        check("t5_busy", 32'(bus.busy_o), 32'd0);
        check("t5_req_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (6) begin
            @(posedge clk_i);
            #1;
            check("t5_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        end
        do_req("t5_ge", 32'd3, 32'd3, CC_GE, 1'b1, 1, 0, 1, 4, 4, 1);

        // Sign decided by the top chunk alone.
        do_req("t6_lt", 32'h80000000, 32'd0, CC_LT, 1'b1, 1, 1, 0, 4, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
